usb_stream_arbiter: RTL

Packet-aware round-robin arbiter that lets several COBS-encoded 8-bit AXI-Stream sources share the single byte stream feeding the FT232H USB FIFO. Typical sources are the low-speed XADC packetizer and a high-speed ADC packetizer. It switches sources only at packet boundaries, so every frame reaching the host is whole. It bounds packet length so that one runaway source cannot starve the others.

---
 rtl/usb_stream_arbiter_pkg.sv | 15 +
 rtl/usb_stream_arbiter_rr_priority_picker.sv | 31 +++
 rtl/usb_stream_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/usb_stream_arbiter_pkg.sv
// Shared types and constants for the packet-aware USB stream arbiter.
package usb_stream_arbiter_package;

  typedef enum logic [2:0] {
    StIdle,
    StTag,
    StPass,
    StAbort,
    StDrain
  } usb_arb_state_t;

  localparam logic [7:0] COBS_DELIMITER = 8'h00;
  localparam logic [7:0] ARB_TAG_BASE   = 8'h01;

endpackage

// File: rtl/usb_stream_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester after index `last`, wrapping.
module rr_priority_picker #(
  parameter int unsigned N_SRC = 2
) (
  input  logic [N_SRC-1:0]         req,
  input  logic [$clog2(N_SRC)-1:0] last,
  output logic [$clog2(N_SRC)-1:0] gnt_idx,
  output logic                     any
);

  localparam int unsigned IdxW = $clog2(N_SRC);

  always_comb begin
    int unsigned best;
    int unsigned off;
    gnt_idx = '0;
    any     = 1'b0;
    best    = N_SRC;
    off     = 0;
    for (int unsigned j = 0; j < N_SRC; j++) begin
      // Distance from the slot after `last`; smallest distance wins.
      off = (j + 2 * N_SRC - 32'(last) - 1) % N_SRC;
      if (req[j] && off < best) begin
        best    = off;
        gnt_idx = IdxW'(j);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_stream_arbiter.sv
// Packet-aware round-robin arbiter for COBS byte streams feeding the FT232H FIFO.
// Define USB_STREAM_ARBITER_TAG_EN to prefix each packet with a source tag byte.
module usb_stream_arbiter
  import usb_stream_arbiter_package::*;
#(
  parameter int unsigned N_SRC         = 2,
  parameter int unsigned MAX_PKT_BYTES = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC*8-1:0]       s_tdata,
  input  logic [N_SRC-1:0]         s_tvalid,
  input  logic [N_SRC-1:0]         s_tlast,
  output logic [N_SRC-1:0]         s_tready,
  output logic [7:0]               m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [$clog2(N_SRC)-1:0] grant,
  output logic                     busy,
  output logic [15:0]              abort_count
);

  localparam int unsigned IdxW = $clog2(N_SRC);

  usb_arb_state_t  state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [15:0]     byte_cnt_q, byte_cnt_d;
  logic [15:0]     abort_cnt_q, abort_cnt_d;

  logic [IdxW-1:0]  pick_idx;
  logic             pick_any;
  logic [7:0]       src_data;
  logic             src_valid;
  logic             src_last;
  logic [N_SRC-1:0] sel;

  rr_priority_picker #(
    .N_SRC(N_SRC)
  ) u_picker (
    .req    (s_tvalid),
    .last   (grant_q),
    .gnt_idx(pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    src_data  = '0;
    src_valid = 1'b0;
    src_last  = 1'b0;
    sel       = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant_q == IdxW'(i)) begin
        sel[i]    = 1'b1;
        src_data  = s_tdata[i*8 +: 8];
        src_valid = s_tvalid[i];
        src_last  = s_tlast[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    byte_cnt_d  = byte_cnt_q;
    abort_cnt_d = abort_cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          byte_cnt_d = '0;
`ifdef USB_STREAM_ARBITER_TAG_EN
          state_d    = StTag;
`else
          state_d    = StPass;
`endif
        end
      end
`ifdef USB_STREAM_ARBITER_TAG_EN
      StTag: begin
        if (m_tready) state_d = StPass;
      end
`endif
      StPass: begin
        if (src_valid && m_tready) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (src_last) begin
            state_d = StIdle;
          end else if (byte_cnt_d == 16'(MAX_PKT_BYTES - 1)) begin
            // Leave room for the delimiter that ABORT appends.
            state_d = StAbort;
            if (abort_cnt_q != 16'hFFFF) abort_cnt_d = abort_cnt_q + 16'd1;
          end
        end
      end
      StAbort: begin
        if (m_tready) state_d = StDrain;
      end
      StDrain: begin
        if (src_valid && src_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_tdata  = COBS_DELIMITER;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    case (state_q)
`ifdef USB_STREAM_ARBITER_TAG_EN
      StTag: begin
        m_tdata  = ARB_TAG_BASE + 8'(grant_q);
        m_tvalid = 1'b1;
      end
`endif
      StPass: begin
        m_tdata  = src_data;
        m_tvalid = src_valid;
        m_tlast  = src_last;
        s_tready = sel & {N_SRC{m_tready}};
      end
      StAbort: begin
        m_tdata  = COBS_DELIMITER;
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
      end
      StDrain: s_tready = sel;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= IdxW'(N_SRC - 1);
      byte_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      byte_cnt_q  <= byte_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q != StIdle);
  assign abort_count = abort_cnt_q;

endmodule
